fetch_stage: RTL

Instruction fetch stage feeding the decode stage. It owns the program counter and issues in-order requests to instruction memory over a valid/ready handshake. Returned words are buffered in a small prefetch queue and presented through the IF/ID pipeline register as `instruction`, `pc_address` and `valid`. Branch, jal and jalr resolution redirects the fetch stream and squashes everything fetched down the wrong path.

---
 rtl/fetch_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction fetch: owns the PC, issues credit-limited in-order imem requests,
// buffers returned words in a prefetch queue and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_address,
    output logic        valid
);

    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int           CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]  DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    logic [31:0]   pc_reg, pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [CW-1:0] q_count_reg, q_count_next;
    logic [AW-1:0] fl_wr_reg, fl_wr_next, fl_rd_reg, fl_rd_next;
    logic [AW-1:0] q_head_reg, q_head_next, q_tail_reg, q_tail_next;
    logic [31:0]   instr_reg, instr_next, pca_reg, pca_next;
    logic          valid_reg, valid_next;

    logic [31:0]   fl_mem     [DEPTH];
    logic [31:0]   q_pc_mem   [DEPTH];
    logic [31:0]   q_word_mem [DEPTH];

    logic [CW:0]   credit_used;
    logic          req_valid, req_fire, rsp_fire, rsp_drop, rsp_keep;
    logic          q_empty, bypass, q_push, q_pop;
    logic [31:0]   rsp_pc;

    // Queued words plus in-flight requests never exceed DEPTH, so the queue cannot overflow.
    assign credit_used = {1'b0, q_count_reg} + {1'b0, outstanding_reg};
    assign req_valid   = rst && !redirect && (credit_used < DEPTH_C);
    assign req_fire    = req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire    = imem_rsp_valid && (outstanding_reg != '0);
    assign rsp_drop    = rsp_fire && (discard_reg != '0);
    assign rsp_keep    = rsp_fire && !rsp_drop;
    assign rsp_pc      = fl_mem[fl_rd_reg];
    assign q_empty     = (q_count_reg == '0);
    assign bypass      = rsp_keep && q_empty && !stall;
    assign q_push      = rsp_keep && !bypass;
    assign q_pop       = !stall && !q_empty;

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_reg;
    assign instruction    = instr_reg;
    assign pc_address     = pca_reg;
    assign valid          = valid_reg;

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        q_count_next     = q_count_reg;
        fl_wr_next       = fl_wr_reg;
        fl_rd_next       = fl_rd_reg;
        q_head_next      = q_head_reg;
        q_tail_next      = q_tail_reg;
        instr_next       = instr_reg;
        pca_next         = pca_reg;
        valid_next       = valid_reg;

        if (req_fire) begin
            pc_next    = pc_reg + 32'd4;
            fl_wr_next = fl_wr_reg + AW'(1);
        end
        if (rsp_fire) begin
            fl_rd_next = fl_rd_reg + AW'(1);
        end
        if (req_fire && !rsp_fire) begin
            outstanding_next = outstanding_reg + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_next = outstanding_reg - CW'(1);
        end
        if (rsp_drop) begin
            discard_next = discard_reg - CW'(1);
        end

        if (q_push) begin
            q_tail_next = q_tail_reg + AW'(1);
        end
        if (q_pop) begin
            q_head_next = q_head_reg + AW'(1);
        end
        if (q_push && !q_pop) begin
            q_count_next = q_count_reg + CW'(1);
        end else if (!q_push && q_pop) begin
            q_count_next = q_count_reg - CW'(1);
        end

        if (!stall) begin
            if (!q_empty) begin
                instr_next = q_word_mem[q_head_reg];
                pca_next   = q_pc_mem[q_head_reg];
                valid_next = 1'b1;
            end else if (bypass) begin
                instr_next = imem_rsp_data;
                pca_next   = rsp_pc;
                valid_next = 1'b1;
            end else begin
                instr_next = NOP;
                valid_next = 1'b0;
            end
        end

        // Redirect overrides stall: squash queue and IF/ID, drop everything still in flight.
        if (redirect) begin
            pc_next      = {redirect_pc[31:2], 2'b00};
            q_count_next = '0;
            q_head_next  = '0;
            q_tail_next  = '0;
            instr_next   = NOP;
            valid_next   = 1'b0;
            discard_next = outstanding_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            q_count_reg     <= '0;
            fl_wr_reg       <= '0;
            fl_rd_reg       <= '0;
            q_head_reg      <= '0;
            q_tail_reg      <= '0;
            instr_reg       <= NOP;
            pca_reg         <= '0;
            valid_reg       <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            q_count_reg     <= q_count_next;
            fl_wr_reg       <= fl_wr_next;
            fl_rd_reg       <= fl_rd_next;
            q_head_reg      <= q_head_next;
            q_tail_reg      <= q_tail_next;
            instr_reg       <= instr_next;
            pca_reg         <= pca_next;
            valid_reg       <= valid_next;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            fl_mem[fl_wr_reg] <= pc_reg;
        end
        if (q_push && !redirect) begin
            q_pc_mem[q_tail_reg]   <= rsp_pc;
            q_word_mem[q_tail_reg] <= imem_rsp_data;
        end
    end

endmodule
